// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg: opcodes, trap vector, sequencer state encodings and opcode class helpers.
package lc3_ctrl_pkg;
  localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_LD = 4'h2, OP_ST = 4'h3;
  localparam logic [3:0] OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7;
  localparam logic [3:0] OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF;
  localparam logic [7:0] TRAP_HALT = 8'h25;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT, S_PAUSE
  } state_t;
  function automatic logic is_mem(input logic [3:0] op);
    return op inside {OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI};
  endfunction
  function automatic logic is_ld(input logic [3:0] op);
    return op inside {OP_LD, OP_LDR, OP_LDI};
  endfunction
  function automatic logic is_ind(input logic [3:0] op);
    return op inside {OP_LDI, OP_STI};
  endfunction
  function automatic logic is_wb(input logic [3:0] op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
  endfunction
endpackage

// File: rtl/lc3_lat_timer.sv
// lc3_lat_timer: loadable 3-bit down-counter with zero flag, shared by both memory wait states.
module lc3_lat_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] val,
  output logic       zero
);
  logic [2:0] cnt;
  assign zero = cnt == 3'd0;
  always_ff @(posedge clk)
    if (rst) cnt <= 3'd0;
    else if (load) cnt <= val;
    else if (!zero) cnt <= cnt - 3'd1;
endmodule

// File: rtl/lc3_ctrl_seq.sv
// lc3_ctrl_seq: LC3 fetch/decode/execute/mem/writeback sequencer; LC3_STEP_EN adds a single-step PAUSE state.
module lc3_ctrl_seq
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [15:0]      instr_in,
  input  logic             step,
  output logic             fetch_start,
  output logic             mem_en,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_load,
  output logic             exec_en,
  output logic             wb_en,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] instr_cnt
);
  state_t state, next, cont;
  logic [3:0] op;
  logic [7:0] tv;
  logic ind, zero;
`ifdef LC3_STEP_EN
  logic unused;
  assign unused = ^instr_in[11:8];
  assign cont = run ? S_PAUSE : S_IDLE;
`else
  logic unused;
  assign unused = ^{step, instr_in[11:8]};
  assign cont = run ? S_FETCH : S_IDLE;
`endif
  lc3_lat_timer u_timer (
    .clk (clk),
    .rst (rst),
    .load(state == S_FETCH || state == S_MEM),
    .val (3'(MEM_LAT - 1)),
    .zero(zero)
  );
  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = run ? S_FETCH : S_IDLE;
      S_FETCH:  next = S_FWAIT;
      S_FWAIT:  next = zero ? S_DECODE : S_FWAIT;
      S_DECODE: next = S_EXEC;
      S_EXEC:   next = (op == OP_RES || (op == OP_TRAP && tv == TRAP_HALT)) ? S_HALT :
                       is_mem(op) ? S_MEM : is_wb(op) ? S_WB : cont;
      S_MEM:    next = S_MWAIT;
      S_MWAIT:  next = !zero ? S_MWAIT : (is_ind(op) && !ind) ? S_MEM : is_ld(op) ? S_WB : cont;
      S_WB:     next = cont;
      S_HALT:   next = S_HALT;
`ifdef LC3_STEP_EN
      S_PAUSE:  next = !run ? S_IDLE : step ? S_FETCH : S_PAUSE;
`endif
      default:  next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= S_IDLE;
      op        <= 4'h0;
      tv        <= 8'h00;
      ind       <= 1'b0;
      illegal   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state <= next;
      if (state == S_DECODE) begin
        op        <= instr_in[15:12];
        tv        <= instr_in[7:0];
        ind       <= 1'b0;
        instr_cnt <= instr_cnt + 1'b1;
      end else if (state == S_MWAIT && zero && is_ind(op)) ind <= 1'b1;
      if (state == S_EXEC && op == OP_RES) illegal <= 1'b1;
    end
  assign fetch_start = state == S_FETCH;
  assign mem_en      = state == S_FETCH || state == S_MEM;
  assign mem_sel     = state == S_MEM;
  // The first (pointer) pass of STI is a read; only the second pass writes.
  assign mem_we      = state == S_MEM && is_mem(op) && !is_ld(op) && (!is_ind(op) || ind);
  assign ir_load     = state == S_DECODE;
  assign exec_en     = state == S_EXEC;
  assign wb_en       = state == S_WB;
  assign halted      = state == S_HALT;
  assign state_out   = state;
endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// tb_lc3_ctrl_seq: table, random and corner-case checks of lc3_ctrl_seq against a cycle-count model.
module tb_lc3_ctrl_seq;
  logic clk = 0, rst = 1, run = 0, step = 0, rst2 = 1, run2 = 0;
  logic [15:0] instr_in = 16'h0000;
  logic [15:0] instr_in2 = 16'h1021;
  logic fetch_start, mem_en, mem_sel, mem_we, ir_load, exec_en, wb_en, halted, illegal;
  logic fetch_start2, mem_en2, mem_sel2, mem_we2, ir_load2, exec_en2, wb_en2, halted2, illegal2;
  logic [3:0] state_out, state_out2;
  logic [15:0] instr_cnt;
  logic [3:0] instr_cnt2;
  int checks = 0, errors = 0;
  logic [15:0] cnt_m = 16'h0;

  typedef struct { int cyc; int dmem; int wseq; int wb; int irl; } obs_t;
  typedef struct { logic [15:0] ins; int cyc; int dmem; int wseq; int wb; } vec_t;

  lc3_ctrl_seq #(.MEM_LAT(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_in(instr_in), .step(step),
    .fetch_start(fetch_start), .mem_en(mem_en), .mem_sel(mem_sel), .mem_we(mem_we),
    .ir_load(ir_load), .exec_en(exec_en), .wb_en(wb_en), .halted(halted),
    .illegal(illegal), .state_out(state_out), .instr_cnt(instr_cnt)
  );
  lc3_ctrl_seq #(.MEM_LAT(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .run(run2), .instr_in(instr_in2), .step(step),
    .fetch_start(fetch_start2), .mem_en(mem_en2), .mem_sel(mem_sel2), .mem_we(mem_we2),
    .ir_load(ir_load2), .exec_en(exec_en2), .wb_en(wb_en2), .halted(halted2),
    .illegal(illegal2), .state_out(state_out2), .instr_cnt(instr_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected per-instruction profile from the opcode class and memory latency.
  function automatic obs_t model(input logic [15:0] ins, input int l);
    obs_t e;
    int op = int'(ins[15:12]);
    e = '{cyc: 3 + l, dmem: 0, wseq: 0, wb: 0, irl: 1};
    if (op inside {1, 5, 9, 14}) e = '{4 + l, 0, 0, 1, 1};
    else if (op inside {2, 6}) e = '{5 + 2 * l, 1, 0, 1, 1};
    else if (op inside {3, 7}) e = '{4 + 2 * l, 1, 1, 0, 1};
    else if (op == 10) e = '{6 + 3 * l, 2, 0, 1, 1};
    else if (op == 11) e = '{5 + 3 * l, 2, 1, 0, 1};
    return e;
  endfunction

  task automatic wait_fetch(input string name);
    for (int i = 0; i < 40 && !fetch_start; i++) @(negedge clk);
    chk(name, fetch_start, 1);
  endtask

  // Called at a negedge where fetch_start is high; returns at the next fetch_start.
  task automatic measure(input logic [15:0] ins, output obs_t got);
    instr_in = ins;
    got = '{0, 0, 0, 0, 0};
    do begin
      got.cyc++;
      if (mem_en && mem_sel) begin
        got.dmem++;
        got.wseq = got.wseq * 2 + int'(mem_we);
      end
      if (wb_en) got.wb++;
      if (ir_load) got.irl++;
      @(negedge clk);
    end while (!fetch_start && got.cyc < 100);
  endtask

  task automatic run_one(input string name, input logic [15:0] ins, input obs_t e);
    obs_t g;
    measure(ins, g);
    cnt_m = cnt_m + 16'h1;
    chk({name, "_cycles"}, g.cyc, e.cyc);
    chk({name, "_dmem"}, g.dmem, e.dmem);
    chk({name, "_we"}, g.wseq, e.wseq);
    chk({name, "_wb"}, g.wb, e.wb);
    chk({name, "_irload"}, g.irl, 1);
    chk({name, "_cnt"}, instr_cnt, cnt_m);
  endtask

  task automatic reset_dut();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    cnt_m = 16'h0;
  endtask

  initial begin
    vec_t tab[10];
    logic [15:0] ins;
    int nf, nw, k, p;
    tab[0] = '{16'h1021, 6, 0, 0, 1};
    tab[1] = '{16'hA002, 12, 2, 0, 1};
    tab[2] = '{16'hB002, 11, 2, 1, 0};
    tab[3] = '{16'h2002, 9, 1, 0, 1};
    tab[4] = '{16'h3002, 8, 1, 1, 0};
    tab[5] = '{16'h0E01, 5, 0, 0, 0};
    tab[6] = '{16'hF021, 5, 0, 0, 0};
    tab[7] = '{16'h903F, 6, 0, 0, 1};
    tab[8] = '{16'hC1C0, 5, 0, 0, 0};
    tab[9] = '{16'h7040, 8, 1, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {fetch_start, mem_en, mem_sel, mem_we, ir_load, exec_en, wb_en, halted, illegal}, 0);
    chk("reset_state", state_out, 0);
    chk("reset_cnt", instr_cnt, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("idle_no_run", {fetch_start, state_out}, 0);

    run = 1;
    instr_in = 16'h1021;
    wait_fetch("first_fetch");
    chk("fetch_port", {mem_en, mem_sel, mem_we}, 3'b100);

    for (int i = 0; i < 10; i++)
      run_one($sformatf("tab%0d", i), tab[i].ins, '{tab[i].cyc, tab[i].dmem, tab[i].wseq, tab[i].wb, 1});

    for (int i = 0; i < 40; i++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'hD) ins[15:12] = 4'h1;
      if (ins[15:12] == 4'hF && ins[7:0] == 8'h25) ins[7:0] = 8'h20;
      run_one($sformatf("rnd%0d_%h", i, ins), ins, model(ins, 2));
    end

    instr_in = 16'h1021;
    run = 0;
    nf = 0; nw = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nf += int'(fetch_start);
      nw += int'(wb_en);
    end
    cnt_m = cnt_m + 16'h1;
    chk("runlow_fetch", nf, 0);
    chk("runlow_wb", nw, 1);
    chk("runlow_idle", {state_out, mem_en, exec_en}, 0);
    chk("runlow_cnt", instr_cnt, cnt_m);
    run = 1;
    @(negedge clk);
    chk("runlow_resume", fetch_start, 1);

    instr_in = 16'hF025;
    nf = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      nf += int'(fetch_start);
    end
    chk("halt_nofetch", nf, 0);
    chk("halt_flags", {halted, illegal}, 2'b10);
    chk("halt_cnt", instr_cnt, cnt_m + 16'h1);

    reset_dut();
    chk("post_halt_reset", {halted, illegal, instr_cnt}, 0);
    wait_fetch("ill_fetch");
    instr_in = 16'hD000;
    nf = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      nf += int'(fetch_start);
    end
    chk("ill_nofetch", nf, 0);
    chk("ill_flags", {halted, illegal}, 2'b11);

    reset_dut();
    wait_fetch("ld_fetch");
    run_one("pre_ld_add", 16'h1021, model(16'h1021, 2));
    instr_in = 16'h2002;
    for (int i = 0; i < 40 && !(mem_en && mem_sel); i++) @(negedge clk);
    chk("ld_mem_seen", {mem_en, mem_sel, mem_we}, 3'b110);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mwait_rst_state", state_out, 0);
    chk("mwait_rst_strobes", {fetch_start, mem_en, mem_sel, mem_we, ir_load, exec_en, wb_en, halted, illegal}, 0);
    chk("mwait_rst_cnt", instr_cnt, 0);
    rst = 0;

    rst2 = 0;
    run2 = 1;
    k = 0;
    for (int i = 0; i < 300 && k < 16; i++) begin
      @(negedge clk);
      if (ir_load2) begin
        k++;
        @(negedge clk);
        if (k == 15) chk("wrap_pre", instr_cnt2, 15);
      end
    end
    chk("wrap_count", k, 16);
    chk("wrap_zero", instr_cnt2, 0);
    for (int i = 0; i < 20 && !fetch_start2; i++) @(negedge clk);
    p = 0;
    do begin
      p++;
      @(negedge clk);
    end while (!fetch_start2 && p < 50);
    chk("lat1_add_period", p, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
